pipl_skid_chain: RTL and testbench

PIPL_SKID_CHAIN -- requirements
Module: pipl_skid_chain

---
 rtl/pipl_skid_chain_pkg.sv | 16 +
 rtl/pipl_skid_chain_stage.sv | 76 +++++++
 rtl/pipl_skid_chain.sv | 81 ++++++++
 tb/tb_pipl_skid_chain.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipl_skid_chain_pkg.sv
// Shared limits and sizing helper for the skid-buffered pipeline chain.
package pipl_skid_chain_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 256;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipl_skid_chain_stage.sv
// One chain stage: a main register plus a skid register.
// Upstream ready depends only on local skid state, never on downstream.
module pipl_skid_stage
  import pipl_skid_chain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i
);

  logic             m_v_q, m_v_d;
  logic             s_v_q, s_v_d;
  logic [WIDTH-1:0] m_d_q, m_d_d;
  logic [WIDTH-1:0] s_d_q, s_d_d;
  logic             live;
  logic             up_fire;
  logic             dn_fire;

  assign live       = en_i & ~flush_i;
  assign up_ready_o = ~s_v_q & live;
  assign dn_valid_o = m_v_q & live;
  assign dn_data_o  = m_d_q;
  assign up_fire    = up_valid_i & up_ready_o;
  assign dn_fire    = dn_valid_o & dn_ready_i;

  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    s_v_d = s_v_q;
    s_d_d = s_d_q;
    if (flush_i) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (s_v_q) begin
      // upstream is stalled while the skid holds data
      if (dn_fire) begin
        m_d_d = s_d_q;
        s_v_d = 1'b0;
      end
    end else if (up_fire) begin
      if (!m_v_q || dn_fire) begin
        m_v_d = 1'b1;
        m_d_d = up_data_i;
      end else begin
        s_v_d = 1'b1;
        s_d_d = up_data_i;
      end
    end else if (dn_fire) begin
      m_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      m_d_q <= '0;
      s_d_q <= '0;
    end else begin
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      m_d_q <= m_d_d;
      s_d_q <= s_d_d;
    end
  end

endmodule

// File: rtl/pipl_skid_chain.sv
// DEPTH-stage skid-buffered pipeline with registered ready and
// an occupancy counter kept alongside the chain.
module pipl_skid_chain
  import pipl_skid_chain_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_BIT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [CNT_BIT-1:0] count,
  output logic               empty
);

  if (CNT_BIT < clog2(2 * DEPTH + 1)) begin : g_cnt_chk
    $error("pipl_skid_chain: CNT_BIT too small for DEPTH");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_w_chk
    $error("pipl_skid_chain: WIDTH out of range");
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_d_chk
    $error("pipl_skid_chain: DEPTH out of range");
  end

  logic [DEPTH:0]   v_w;
  logic [DEPTH:0]   r_w;
  logic [WIDTH-1:0] d_w [DEPTH+1];

  assign v_w[0]     = in_valid;
  assign d_w[0]     = in_data;
  assign r_w[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipl_skid_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .flush_i    (flush),
      .up_valid_i (v_w[k]),
      .up_data_i  (d_w[k]),
      .up_ready_o (r_w[k]),
      .dn_valid_o (v_w[k+1]),
      .dn_data_o  (d_w[k+1]),
      .dn_ready_i (r_w[k+1])
    );
  end

  logic               acc;
  logic               emit;
  logic [CNT_BIT-1:0] count_q, count_d;

  assign in_ready  = r_w[0] & ~rst;
  assign out_valid = v_w[DEPTH];
  assign out_data  = d_w[DEPTH];
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign count     = count_q;
  assign empty     = (count_q == '0);

  always_comb begin
    count_d = count_q + CNT_BIT'(acc) - CNT_BIT'(emit);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: tb/tb_pipl_skid_chain.sv
// Bench for pipl_skid_chain: directed scenarios plus a randomized run
// against a FIFO-queue reference model.
module tb_pipl_skid_chain;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CB = 5;

  logic          clk = 1'b0;
  logic          rst, en, flush, in_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic          in_ready, out_valid, empty;
  logic [CB-1:0] count;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  logic [W-1:0] mq[$];
  int           tq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  pipl_skid_chain #(.WIDTH(W), .DEPTH(D), .CNT_BIT(CB)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .empty(empty)
  );

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  // One cycle: sample handshakes at negedge, update the model after the edge.
  task automatic tick(output bit acc, output bit emi,
                      output logic [W-1:0] od, output logic [W-1:0] ex,
                      output int lat);
    logic [W-1:0] id;
    bit fl;
    int now;
    @(negedge clk);
    acc = in_valid && in_ready;
    emi = out_valid && out_ready;
    od  = out_data;
    id  = in_data;
    fl  = flush;
    now = cyc_n;
    ex  = 'x;
    lat = -1;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      tq.delete();
    end else begin
      if (emi && mq.size() > 0) begin
        ex  = mq.pop_front();
        lat = now - tq.pop_front();
      end
      if (acc) begin
        mq.push_back(id);
        tq.push_back(now);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got=%0d want=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b want=1", empty); end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    bit a, e;
    logic [W-1:0] od, ex;
    int lat, ne, first, last;
    ne = 0; first = -1; last = -1;
    out_ready = 1;
    for (int i = 0; i < 24 && ne < 8; i++) begin
      in_valid = (i < 8);
      in_data  = 32'h11 + 32'(i);
      tick(a, e, od, ex, lat);
      if (i < 8) begin
        checks++; if (!a) begin errors++; $display("FAIL lat_accept i=%0d got=0 want=1", i); end
      end
      if (e) begin
        checks++; if (od !== 32'h11 + 32'(ne)) begin errors++; $display("FAIL lat_data got=%h want=%h", od, 32'h11 + 32'(ne)); end
        checks++; if (lat != D) begin errors++; $display("FAIL lat_cycles got=%0d want=%0d", lat, D); end
        if (first < 0) first = i;
        last = i;
        ne++;
      end
    end
    in_valid = 0;
    checks++; if (ne != 8) begin errors++; $display("FAIL lat_emits got=%0d want=8", ne); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL lat_b2b span got=%0d want=7", last - first); end
  endtask

  task automatic test_fill();
    bit a, e;
    logic [W-1:0] od, ex;
    int lat, na, ne;
    na = 0; ne = 0;
    out_ready = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1;
      in_data  = $urandom;
      tick(a, e, od, ex, lat);
      if (a) na++;
    end
    in_valid = 0;
    checks++; if (na != 2 * D) begin errors++; $display("FAIL fill_accepts got=%0d want=%0d", na, 2 * D); end
    checks++; if (count !== CB'(2 * D)) begin errors++; $display("FAIL fill_count got=%0d want=%0d", count, 2 * D); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid got=%b want=1", out_valid); end
    out_ready = 1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) begin
      tick(a, e, od, ex, lat);
      if (e) begin
        ne++;
        checks++; if (od !== ex) begin errors++; $display("FAIL fill_order got=%h want=%h", od, ex); end
      end
    end
    checks++; if (ne != 2 * D) begin errors++; $display("FAIL fill_emits got=%0d want=%0d", ne, 2 * D); end
    checks++; if (count !== '0) begin errors++; $display("FAIL fill_count_end got=%0d want=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got=%b want=1", empty); end
  endtask

  task automatic test_flush();
    bit a, e, seen;
    logic [W-1:0] od, ex, x;
    int lat;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data  = $urandom;
      tick(a, e, od, ex, lat);
      checks++; if (!a) begin errors++; $display("FAIL fl_push i=%0d got=0 want=1", i); end
    end
    flush = 1; in_valid = 1; in_data = $urandom; out_ready = 1;
    tick(a, e, od, ex, lat);
    checks++; if (a) begin errors++; $display("FAIL fl_accept got=1 want=0"); end
    checks++; if (e) begin errors++; $display("FAIL fl_out_valid got=1 want=0"); end
    flush = 0;
    checks++; if (count !== '0) begin errors++; $display("FAIL fl_count got=%0d want=0", count); end
    x = 32'hC0DE_0000 | 32'($urandom_range(1, 255));
    in_valid = 1; in_data = x;
    tick(a, e, od, ex, lat);
    in_valid = 0;
    checks++; if (!a) begin errors++; $display("FAIL fl_repush got=0 want=1"); end
    checks++; if (e) begin errors++; $display("FAIL fl_next_valid got=1 want=0"); end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(a, e, od, ex, lat);
      if (e) begin
        seen = 1;
        checks++; if (od !== x) begin errors++; $display("FAIL fl_data got=%h want=%h", od, x); end
        checks++; if (lat != D) begin errors++; $display("FAIL fl_lat got=%0d want=%0d", lat, D); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL fl_emerge got=none want=%h", x); end
  endtask

  task automatic test_enable();
    bit a, e;
    logic [W-1:0] od, ex;
    logic [W-1:0] ref3 [3];
    int lat, ne;
    ne = 0;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      ref3[i]  = $urandom;
      in_data  = ref3[i];
      tick(a, e, od, ex, lat);
      checks++; if (!a) begin errors++; $display("FAIL en_push i=%0d got=0 want=1", i); end
    end
    en = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'($urandom);
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready got=%b want=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_out_valid got=%b want=0", out_valid); end
      @(posedge clk); #1;
      checks++; if (count !== CB'(3)) begin errors++; $display("FAIL en_count got=%0d want=3", count); end
    end
    en = 1; out_ready = 1; in_valid = 0;
    for (int i = 0; i < 20 && ne < 3; i++) begin
      tick(a, e, od, ex, lat);
      if (e) begin
        checks++; if (od !== ref3[ne]) begin errors++; $display("FAIL en_order got=%h want=%h", od, ref3[ne]); end
        ne++;
      end
    end
    checks++; if (ne != 3) begin errors++; $display("FAIL en_emits got=%0d want=3", ne); end
    checks++; if (count !== '0) begin errors++; $display("FAIL en_count_end got=%0d want=0", count); end
  endtask

  task automatic test_async_reset();
    bit a, e;
    logic [W-1:0] od, ex;
    int lat;
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_data  = $urandom | 32'h1;
      tick(a, e, od, ex, lat);
    end
    in_valid = 0;
    repeat (4) tick(a, e, od, ex, lat);
    @(negedge clk); #2;
    rst = 1; #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL ar_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL ar_out_data got=%h want=0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready got=%b want=0", in_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ar_empty got=%b want=1", empty); end
    mq.delete();
    tq.delete();
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_rel_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      tick(a, e, od, ex, lat);
      checks++; if (e) begin errors++; $display("FAIL ar_stale got=%h want=none", od); end
    end
  endtask

  task automatic test_random();
    bit a, e, en_s;
    logic [W-1:0] od, ex;
    int lat, sz;
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom % 10) != 0;
      flush     = ($urandom % 50) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      out_ready = ($urandom % 4) < (i / 150);
      sz   = mq.size();
      en_s = en;
      tick(a, e, od, ex, lat);
      if (sz == 2 * D) begin
        checks++; if (a) begin errors++; $display("FAIL rnd_full_accept cyc=%0d got=1 want=0", i); end
      end
      if (!en_s) begin
        checks++; if (a || e) begin errors++; $display("FAIL rnd_en_freeze cyc=%0d got=%b%b want=00", i, a, e); end
      end
      if (e) begin
        checks++; if (od !== ex) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, od, ex); end
        checks++; if (lat < D) begin errors++; $display("FAIL rnd_lat cyc=%0d got=%0d want>=%0d", i, lat, D); end
      end
      checks++; if (count !== CB'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, count, mq.size()); end
      checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b want=%b", i, empty, mq.size() == 0); end
    end
    en = 1; flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) begin
      tick(a, e, od, ex, lat);
      if (e) begin
        checks++; if (od !== ex) begin errors++; $display("FAIL rnd_drain got=%h want=%h", od, ex); end
      end
    end
    checks++; if (mq.size() != 0) begin errors++; $display("FAIL rnd_left got=%0d want=0", mq.size()); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rnd_count_end got=%0d want=0", count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_flush();
    test_enable();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
